// File: rtl/fetch_ifid_stage_if.sv
// Fetch-stage bus: hazard-unit stall controls, branch redirect, instruction-memory
// port and the IF/ID register outputs consumed by decode.
interface fetch_ifid_stage_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               inc_pc;
    logic               write_ifid;
    logic               flush;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_rdy;
    logic [INSTR_W-1:0] instr_id;
    logic [PC_W-1:0]    pc_id;
    logic [PC_W-1:0]    pc_plus1_id;
    logic               valid_id;
    logic               halted;

    // master is the fetch stage itself; slave is the surrounding pipeline and memory
    modport master (
        input  inc_pc, write_ifid, flush, redirect_pc, imem_rdata, imem_rdy,
        output imem_addr, instr_id, pc_id, pc_plus1_id, valid_id, halted
    );

    modport slave (
        output inc_pc, write_ifid, flush, redirect_pc, imem_rdata, imem_rdy,
        input  imem_addr, instr_id, pc_id, pc_plus1_id, valid_id, halted
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: program counter, imem addressing and IF/ID register.
// Optional halt-opcode detection is enabled with `define FETCH_HALT_DETECT_EN.
module fetch_ifid_stage #(
    parameter int               PC_W        = 8,
    parameter int               INSTR_W     = 16,
    parameter logic [PC_W-1:0]  RESET_PC    = '0,
    parameter logic [3:0]       HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_ifid_stage_if.master bus
);

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_p1, instr_d;
    logic [PC_W-1:0]    pc_p1, pc_id_d;
    logic [PC_W-1:0]    pc_plus1_p1, pc_plus1_d;
    logic               vld_p1, vld_d;
    logic               running;
    logic               advance;

    assign advance = running & bus.inc_pc & bus.write_ifid & bus.imem_rdy & ~bus.flush;

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
    state_t state_q, state_d;
    logic   halt_hit;

    assign halt_hit = (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // flush always wins; a halt fetched together with a flush never gets here
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:  if (advance && halt_hit) state_d = HALT;
            HALT: if (bus.flush)           state_d = RUN;
            default:                       state_d = RUN;
        endcase
    end

    assign running    = (state_q == RUN);
    assign bus.halted = (state_q == HALT);
`else
    assign running    = 1'b1;
    assign bus.halted = 1'b0;
`endif

    // ---- stage 0: PC select and IF/ID next value ----
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_p1;
        pc_id_d    = pc_p1;
        pc_plus1_d = pc_plus1_p1;
        vld_d      = vld_p1;

        if (bus.flush)    pc_d = bus.redirect_pc;
        else if (advance) pc_d = pc_inc(pc_q);

        // bubbles clear instr/valid but keep the last PC tags
        if (bus.flush) begin
            instr_d = '0;
            vld_d   = 1'b0;
        end else if (!bus.write_ifid) begin
            vld_d   = vld_p1;
        end else if (advance) begin
            instr_d    = bus.imem_rdata;
            pc_id_d    = pc_q;
            pc_plus1_d = pc_inc(pc_q);
            vld_d      = 1'b1;
        end else begin
            instr_d = '0;
            vld_d   = 1'b0;
        end
    end

    // ---- stage 1: PC and IF/ID registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            instr_p1    <= '0;
            pc_p1       <= '0;
            pc_plus1_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            instr_p1    <= instr_d;
            pc_p1       <= pc_id_d;
            pc_plus1_p1 <= pc_plus1_d;
            vld_p1      <= vld_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_id    = instr_p1;
    assign bus.pc_id       = pc_p1;
    assign bus.pc_plus1_id = pc_plus1_p1;
    assign bus.valid_id    = vld_p1;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed scenarios plus randomized traffic checked
// against an instruction-stream reference model.
module tb_fetch_ifid_stage;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_ifid_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_ifid_stage #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00), .HALT_OPCODE(4'hF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    assign bus.imem_rdata = mem[bus.imem_addr];

    // reference model of the fetch stream
    logic [7:0]  m_pc, m_pcid, m_pc1;
    logic [15:0] m_instr;
    logic        m_valid, m_halt;

    task automatic model_reset();
        m_pc = 8'h00; m_pcid = 8'h00; m_pc1 = 8'h00;
        m_instr = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
    endtask

    task automatic mem_default();
        for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
    endtask

    task automatic step();
        logic [15:0] fetched;
        logic        fetch_ok;
        fetched  = mem[m_pc];
        fetch_ok = !m_halt && bus.inc_pc && bus.write_ifid && bus.imem_rdy && !bus.flush;
        @(posedge clk);
        #1;
        if (bus.flush) begin
            m_pc = bus.redirect_pc;
            m_instr = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
        end else if (fetch_ok) begin
            m_instr = fetched; m_pcid = m_pc; m_pc1 = m_pc + 8'd1; m_valid = 1'b1;
            m_pc = m_pc + 8'd1;
            if (HALT_EN && fetched[15:12] == 4'hF) m_halt = 1'b1;
        end else if (bus.write_ifid) begin
            m_instr = 16'h0; m_valid = 1'b0;
        end
    endtask

    task automatic set_in(input logic inc, input logic wr, input logic fl,
                          input logic [7:0] rpc, input logic rdy);
        bus.inc_pc = inc; bus.write_ifid = wr; bus.flush = fl;
        bus.redirect_pc = rpc; bus.imem_rdy = rdy;
    endtask

    task automatic test_reset();
        mem_default();
        set_in(1, 1, 0, 8'h00, 1);
        rst_n = 1'b0;
        #12;
        model_reset();
        n_vec++;
        if ({bus.imem_addr, bus.instr_id, bus.pc_id, bus.pc_plus1_id, bus.valid_id, bus.halted}
            !== {8'h00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values got %h %h %h %h %b %b want 00 0000 00 00 0 0",
                     bus.imem_addr, bus.instr_id, bus.pc_id, bus.pc_plus1_id, bus.valid_id, bus.halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] kk;
            kk = 8'(k);
            step();
            n_vec++;
            if ({bus.instr_id, bus.pc_id, bus.pc_plus1_id, bus.valid_id}
                !== {16'h1000 + 16'(k), kk, kk + 8'd1, 1'b1}) begin
                n_err++;
                $display("FAIL seq_fetch%0d got instr=%h pc=%h pc1=%h v=%b want instr=%h pc=%h",
                         k, bus.instr_id, bus.pc_id, bus.pc_plus1_id, bus.valid_id, 16'h1000 + 16'(k), kk);
            end
        end
    endtask

    task automatic test_stall();
        step(); step();
        n_vec++;
        if ({bus.imem_addr, bus.pc_id, bus.instr_id} !== {8'h05, 8'h04, 16'h1004}) begin
            n_err++;
            $display("FAIL stall_setup got addr=%h pc=%h instr=%h want 05 04 1004",
                     bus.imem_addr, bus.pc_id, bus.instr_id);
        end
        set_in(0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if ({bus.imem_addr, bus.instr_id, bus.pc_id, bus.valid_id} !== {8'h05, 16'h1004, 8'h04, 1'b1}) begin
                n_err++;
                $display("FAIL stall_hold%0d got addr=%h instr=%h pc=%h v=%b want 05 1004 04 1",
                         k, bus.imem_addr, bus.instr_id, bus.pc_id, bus.valid_id);
            end
        end
        set_in(1, 1, 0, 8'h00, 1);
        step();
        n_vec++;
        if ({bus.pc_id, bus.instr_id, bus.valid_id, bus.imem_addr} !== {8'h05, 16'h1005, 1'b1, 8'h06}) begin
            n_err++;
            $display("FAIL stall_release got pc=%h instr=%h v=%b addr=%h want 05 1005 1 06",
                     bus.pc_id, bus.instr_id, bus.valid_id, bus.imem_addr);
        end
    endtask

    task automatic test_mem_wait();
        step();
        set_in(1, 1, 0, 8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if ({bus.imem_addr, bus.instr_id, bus.valid_id, bus.pc_id} !== {8'h07, 16'h0000, 1'b0, 8'h06}) begin
                n_err++;
                $display("FAIL memwait_bubble%0d got addr=%h instr=%h v=%b pc=%h want 07 0000 0 06",
                         k, bus.imem_addr, bus.instr_id, bus.valid_id, bus.pc_id);
            end
        end
        set_in(1, 1, 0, 8'h00, 1);
        step();
        n_vec++;
        if ({bus.pc_id, bus.instr_id, bus.valid_id} !== {8'h07, 16'h1007, 1'b1}) begin
            n_err++;
            $display("FAIL memwait_resume got pc=%h instr=%h v=%b want 07 1007 1",
                     bus.pc_id, bus.instr_id, bus.valid_id);
        end
    endtask

    task automatic test_flush();
        set_in(1, 0, 1, 8'h40, 1);
        step();
        n_vec++;
        if ({bus.valid_id, bus.instr_id, bus.imem_addr} !== {1'b0, 16'h0000, 8'h40}) begin
            n_err++;
            $display("FAIL flush_bubble got v=%b instr=%h addr=%h want 0 0000 40",
                     bus.valid_id, bus.instr_id, bus.imem_addr);
        end
        set_in(1, 1, 0, 8'h00, 1);
        step();
        n_vec++;
        if ({bus.pc_id, bus.instr_id, bus.valid_id} !== {8'h40, 16'h1040, 1'b1}) begin
            n_err++;
            $display("FAIL flush_target got pc=%h instr=%h v=%b want 40 1040 1",
                     bus.pc_id, bus.instr_id, bus.valid_id);
        end
    endtask

    task automatic test_wrap();
        set_in(1, 1, 1, 8'hFF, 1);
        step();
        set_in(1, 1, 0, 8'h00, 1);
        step();
        n_vec++;
        if ({bus.pc_id, bus.pc_plus1_id, bus.imem_addr, bus.instr_id} !== {8'hFF, 8'h00, 8'h00, 16'h10FF}) begin
            n_err++;
            $display("FAIL wrap_ff got pc=%h pc1=%h addr=%h instr=%h want FF 00 00 10FF",
                     bus.pc_id, bus.pc_plus1_id, bus.imem_addr, bus.instr_id);
        end
        step();
        n_vec++;
        if ({bus.pc_id, bus.instr_id, bus.valid_id} !== {8'h00, 16'h1000, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_00 got pc=%h instr=%h v=%b want 00 1000 1",
                     bus.pc_id, bus.instr_id, bus.valid_id);
        end
    endtask

    task automatic test_halt();
        mem[3] = 16'hF000;
        set_in(1, 1, 1, 8'h03, 1);
        step();
        // halt opcode on imem_rdata together with flush must be discarded
        set_in(1, 1, 1, 8'h20, 1);
        step();
        n_vec++;
        if ({bus.halted, bus.imem_addr, bus.valid_id} !== {1'b0, 8'h20, 1'b0}) begin
            n_err++;
            $display("FAIL halt_flush_discard got halted=%b addr=%h v=%b want 0 20 0",
                     bus.halted, bus.imem_addr, bus.valid_id);
        end
        set_in(1, 1, 1, 8'h03, 1);
        step();
        set_in(1, 1, 0, 8'h00, 1);
        step();
        n_vec++;
        if ({bus.pc_id, bus.valid_id, bus.halted, bus.instr_id, bus.imem_addr}
            !== {8'h03, 1'b1, HALT_EN, 16'hF000, 8'h04}) begin
            n_err++;
            $display("FAIL halt_fetch got pc=%h v=%b halted=%b instr=%h addr=%h want 03 1 %b F000 04",
                     bus.pc_id, bus.valid_id, bus.halted, bus.instr_id, bus.imem_addr, HALT_EN);
        end
`ifdef FETCH_HALT_DETECT_EN
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if ({bus.valid_id, bus.instr_id, bus.halted, bus.imem_addr} !== {1'b0, 16'h0000, 1'b1, 8'h04}) begin
                n_err++;
                $display("FAIL halt_frozen%0d got v=%b instr=%h halted=%b addr=%h want 0 0000 1 04",
                         k, bus.valid_id, bus.instr_id, bus.halted, bus.imem_addr);
            end
        end
        set_in(1, 1, 1, 8'h10, 1);
        step();
        n_vec++;
        if ({bus.halted, bus.imem_addr, bus.valid_id} !== {1'b0, 8'h10, 1'b0}) begin
            n_err++;
            $display("FAIL halt_exit got halted=%b addr=%h v=%b want 0 10 0",
                     bus.halted, bus.imem_addr, bus.valid_id);
        end
        set_in(1, 1, 0, 8'h00, 1);
        step();
        n_vec++;
        if ({bus.pc_id, bus.instr_id, bus.valid_id} !== {8'h10, 16'h1010, 1'b1}) begin
            n_err++;
            $display("FAIL halt_resume got pc=%h instr=%h v=%b want 10 1010 1",
                     bus.pc_id, bus.instr_id, bus.valid_id);
        end
`else
        step();
        n_vec++;
        if ({bus.pc_id, bus.instr_id, bus.valid_id, bus.halted} !== {8'h04, 16'h1004, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL halt_passthru got pc=%h instr=%h v=%b halted=%b want 04 1004 1 0",
                     bus.pc_id, bus.instr_id, bus.valid_id, bus.halted);
        end
`endif
        mem[3] = 16'h1003;
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 0, 8'h00, 1);
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({bus.imem_addr, bus.instr_id, bus.pc_id, bus.pc_plus1_id, bus.valid_id, bus.halted}
            !== {8'h00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_async got %h %h %h %h %b %b want 00 0000 00 00 0 0",
                     bus.imem_addr, bus.instr_id, bus.pc_id, bus.pc_plus1_id, bus.valid_id, bus.halted);
        end
        set_in(1, 1, 0, 8'h00, 1);
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.imem_addr, bus.valid_id} !== {8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset_held got addr=%h v=%b want 00 0", bus.imem_addr, bus.valid_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({bus.pc_id, bus.instr_id, bus.valid_id} !== {8'h00, 16'h1000, 1'b1}) begin
            n_err++;
            $display("FAIL reset_refetch got pc=%h instr=%h v=%b want 00 1000 1",
                     bus.pc_id, bus.instr_id, bus.valid_id);
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 256; a++) begin
            mem[a] = 16'($urandom);
            if ($urandom_range(0, 7) != 0 && mem[a][15:12] == 4'hF) mem[a][15:12] = 4'h3;
        end
        for (int k = 0; k < 600; k++) begin
            set_in($urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                   $urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 6) != 0);
            step();
            n_vec++;
            if ({bus.imem_addr, bus.instr_id, bus.pc_id, bus.pc_plus1_id, bus.valid_id, bus.halted}
                !== {m_pc, m_instr, m_pcid, m_pc1, m_valid, m_halt}) begin
                n_err++;
                $display("FAIL random%0d got addr=%h instr=%h pc=%h pc1=%h v=%b h=%b want %h %h %h %h %b %b",
                         k, bus.imem_addr, bus.instr_id, bus.pc_id, bus.pc_plus1_id, bus.valid_id, bus.halted,
                         m_pc, m_instr, m_pcid, m_pc1, m_valid, m_halt);
            end
        end
    endtask

    initial begin
        set_in(1, 1, 0, 8'h00, 1);
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_mem_wait();
        test_flush();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
